// File: rtl/sync_fifo_lutram_prog.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_lutram_prog
// Description : Single-clock distributed-RAM FIFO with FWFT/standard read,
//               runtime almost-full/empty thresholds and optional sticky
//               error flags (enabled by SYNC_FIFO_LUTRAM_ERR_FLAG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_lutram_prog #(
    parameter     fwft_mode        = "true",
    parameter int fifo_depth       = 32,
    parameter int fifo_data_width  = 32,
    parameter int simulation_delay = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_flush,
    input  logic                             fifo_wen,
    input  logic [fifo_data_width-1:0]       fifo_din,
    output logic                             fifo_full,
    output logic                             fifo_full_n,
    input  logic [$clog2(fifo_depth):0]      almost_full_th,
    output logic                             fifo_almost_full,
    output logic                             fifo_almost_full_n,
    input  logic                             fifo_ren,
    output logic [fifo_data_width-1:0]       fifo_dout,
    output logic                             fifo_empty,
    output logic                             fifo_empty_n,
    input  logic [$clog2(fifo_depth):0]      almost_empty_th,
    output logic                             fifo_almost_empty,
    output logic                             fifo_almost_empty_n,
    output logic [$clog2(fifo_depth):0]      data_cnt,
    input  logic                             err_clr,
    output logic                             overflow_err,
    output logic                             underflow_err
);

    localparam int         c_aw       = $clog2(fifo_depth);
    localparam logic       c_fwft     = (fwft_mode == "true");
    localparam logic [c_aw:0] c_full_cnt = (c_aw+1)'(fifo_depth);

    logic [fifo_data_width-1:0] r_mem [0:fifo_depth-1];
    logic [c_aw-1:0]            r_wr_ptr;
    logic [c_aw-1:0]            r_rd_ptr;
    logic [c_aw:0]              r_cnt;
    logic                       r_full;
    logic                       r_empty;
    logic                       r_almost_full;
    logic                       r_almost_empty;
    logic [fifo_data_width-1:0] r_dout;

    logic                       w_wr_acc;
    logic                       w_rd_acc;
    logic [c_aw-1:0]            w_wr_ptr_nxt;
    logic [c_aw-1:0]            w_rd_ptr_nxt;
    logic [c_aw:0]              w_cnt_nxt;

    // Flush masks both requests so it wins over any traffic in its cycle.
    assign w_wr_acc = fifo_wen & ~r_full  & ~fifo_flush;
    assign w_rd_acc = fifo_ren & ~r_empty & ~fifo_flush;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_cnt_nxt    = r_cnt;
        if (fifo_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_cnt_nxt    = '0;
        end else begin
            if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            if (w_wr_acc && !w_rd_acc)
                w_cnt_nxt = r_cnt + 1'b1;
            else if (!w_wr_acc && w_rd_acc)
                w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_cnt          <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            if (fifo_flush) begin
                r_full         <= 1'b0;
                r_empty        <= 1'b1;
                r_almost_full  <= 1'b0;
                r_almost_empty <= 1'b1;
            end else begin
                r_full         <= (w_cnt_nxt == c_full_cnt);
                r_empty        <= (w_cnt_nxt == '0);
                r_almost_full  <= (w_cnt_nxt >= almost_full_th);
                r_almost_empty <= (w_cnt_nxt <= almost_empty_th);
            end
        end
    end

    // Storage is deliberately unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= fifo_din;
    end

    generate
        if (c_fwft) begin : g_fwft
            // A word written into the slot that becomes the head this cycle
            // is not in the RAM yet, so forward it straight from fifo_din.
            logic w_bypass;
            assign w_bypass = w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_dout <= '0;
                else if (!fifo_flush && (w_cnt_nxt != '0))
                    r_dout <= w_bypass ? fifo_din : r_mem[w_rd_ptr_nxt];
            end
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_dout <= '0;
                else if (w_rd_acc)
                    r_dout <= r_mem[r_rd_ptr];
            end
        end
    endgenerate

`ifdef SYNC_FIFO_LUTRAM_ERR_FLAG_EN
    // Set has priority over clear so a coincident fault is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow_err  <= (fifo_wen & r_full)  | (overflow_err  & ~err_clr);
            underflow_err <= (fifo_ren & r_empty) | (underflow_err & ~err_clr);
        end
    end
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow_err     = 1'b0;
    assign underflow_err    = 1'b0;
`endif

    logic w_unused_sim_delay;
    assign w_unused_sim_delay = (simulation_delay != 0);

    assign fifo_dout           = r_dout;
    assign data_cnt            = r_cnt;
    assign fifo_full           = r_full;
    assign fifo_full_n         = ~r_full;
    assign fifo_empty          = r_empty;
    assign fifo_empty_n        = ~r_empty;
    assign fifo_almost_full    = r_almost_full;
    assign fifo_almost_full_n  = ~r_almost_full;
    assign fifo_almost_empty   = r_almost_empty;
    assign fifo_almost_empty_n = ~r_almost_empty;

endmodule
`default_nettype wire
